// File: rtl/fc_dot_accum.sv
`default_nettype none
// ============================================================================
// Module   : fc_dot_accum
// Brief    : Signed multiply-accumulate over VEC_LEN operand pairs. Presents a
//            32-bit saturated neuron sum through a valid/ready handshake.
// Revision : 1.0  initial release
// ============================================================================
module fc_dot_accum #(
  parameter int DATA_W  = 16,
  parameter int ACC_W   = 40,
  parameter int VEC_LEN = 64,
  parameter int CNT_W   = $clog2(VEC_LEN + 1)
) (
  input  logic              aclk,
  input  logic              aresetn,
  input  logic [31:0]       iStart,
  input  logic [DATA_W-1:0] iData,
  input  logic [DATA_W-1:0] iWeight,
  input  logic              iValid,
  input  logic              iReady,
  output logic [31:0]       oResult,
  output logic              oValid,
  output logic              oBusy,
  output logic              oErr
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ACCUM = 2'd1,
    S_OUT   = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] c_cnt_last = CNT_W'(VEC_LEN);
  localparam logic [CNT_W-1:0] c_cnt_pen  = CNT_W'(VEC_LEN - 1);

  state_t                    r_state;
  state_t                    w_state_next;
  logic signed [ACC_W-1:0]   r_acc;
  logic signed [ACC_W-1:0]   w_acc_next;
  logic [CNT_W-1:0]          r_cnt;
  logic [CNT_W-1:0]          w_cnt_next;
  logic [31:0]               r_result;
  logic                      r_valid;
  logic                      r_busy;
  logic                      r_err;
  logic                      w_start;
  logic                      w_load_out;
  logic                      w_err;
  logic signed [2*DATA_W-1:0] w_prod;
  logic signed [ACC_W-1:0]   w_prod_ext;
  logic [ACC_W-32:0]         w_hi;
  logic [31:0]               w_sat;

  assign w_start    = |iStart;
  assign w_prod     = $signed(iData) * $signed(iWeight);
  assign w_prod_ext = ACC_W'(w_prod);

  // Bits 31 and above all equal means the sum fits in 32 signed bits.
  assign w_hi  = w_acc_next[ACC_W-1:31];
  assign w_sat = ((&w_hi) || !(|w_hi)) ? w_acc_next[31:0]
               : (w_acc_next[ACC_W-1] ? 32'h8000_0000 : 32'h7FFF_FFFF);

  always_comb begin
    w_state_next = r_state;
    w_acc_next   = r_acc;
    w_cnt_next   = r_cnt;
    w_load_out   = 1'b0;
    w_err        = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_start) begin
          w_acc_next = iValid ? w_prod_ext : '0;
          w_cnt_next = CNT_W'(iValid);
          if (iValid && (c_cnt_last == CNT_W'(1))) begin
            w_state_next = S_OUT;
            w_load_out   = 1'b1;
          end else begin
            w_state_next = S_ACCUM;
          end
        end
      end
      S_ACCUM: begin
        w_err = w_start;
        if (iValid) begin
          w_acc_next = r_acc + w_prod_ext;
          w_cnt_next = r_cnt + CNT_W'(1);
          if (r_cnt == c_cnt_pen) begin
            w_state_next = S_OUT;
            w_load_out   = 1'b1;
          end
        end
      end
      S_OUT: begin
        // A start in the handshake cycle is flagged but never restarts.
        w_err = w_start;
        if (iReady) begin
          w_state_next = S_IDLE;
        end
      end
      default: begin
        w_state_next = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      r_state  <= S_IDLE;
      r_acc    <= '0;
      r_cnt    <= '0;
      r_result <= '0;
      r_valid  <= 1'b0;
      r_busy   <= 1'b0;
      r_err    <= 1'b0;
    end else begin
      r_state <= w_state_next;
      r_acc   <= w_acc_next;
      r_cnt   <= w_cnt_next;
      r_valid <= (w_state_next == S_OUT);
      r_busy  <= (w_state_next != S_IDLE);
      r_err   <= w_err;
      if (w_load_out) begin
        r_result <= w_sat;
      end
    end
  end

  assign oResult = r_result;
  assign oValid  = r_valid;
  assign oBusy   = r_busy;
  assign oErr    = r_err;

endmodule
`default_nettype wire
